phase_sequencer: RTL
====================

# phase_sequencer

Synchronous phase sequencer that drives the 2-bit address and active-low enable inputs of a downstream hct74139 half-decoder. It steps the decoder through 1–4 consecutive output lines, one per phase. Enable is always deasserted around every address change, so the decoder's 13 ns address-to-output path can never glitch an active strobe. It sits between control logic, which issues start/abort, and the 74139 that generates the per-device strobes.

## Interface
- `STROBE_CYCLES`, default 2: clock cycles `_E` is held low per phase; legal range 1..15.
- `LOG`, default 0: when 1, print state transitions via `$display`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `MR`  in  1  master reset, synchronous, active-high; overrides all other inputs.
- `start`  in  1  request a sequence; sampled only in IDLE.
- `first`  in  2  address of the first phase; latched with `start`.
- `count`  in  2  number of phases minus 1 (0..3 → 1..4 phases); latched with `start`.
- `abort`  in  1  terminate the running sequence.
- `A`  out  2  address to the decoder (Aa/Ab).
- `_E`  out  1  active-low enable to the decoder (_Ea/_Eb).
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- All outputs are registered. Reset values: `A`=00, `_E`=1, `busy`=0, `done`=0, state IDLE.
- States:
  - **IDLE:** `_E`=1, `busy`=0, `A` holds its last value. On `start`=1 and `abort`=0: latch `count` into a 2-bit remaining counter, set `A`←`first`, go to SETUP.
  - **SETUP (1 cycle):** `_E`=1, `busy`=1, `A` stable. Next state is STROBE.
  - **STROBE (`STROBE_CYCLES` cycles):** `_E`=0, `A` stable. A down-counter loaded with `STROBE_CYCLES`−1 sets the dwell. When it expires, go to HOLD.
  - **HOLD (1 cycle):** `_E`=1, `A` still stable.
    - If remaining = 0, go to DONE.
    - Otherwise `A`←`A`+1 modulo 4 (11→00 wraps), decrement remaining, go to SETUP.
  - **DONE (1 cycle):** `done`=1, `busy`=1, `_E`=1. Next state is IDLE. `start` is ignored in this state.
- `A` changes only on the edge entering SETUP, and that edge always sees `_E`=1 both before and after. `A` and `_E` never change on the same edge.
- `abort`=1 in any non-IDLE state: the next edge forces `_E`=1, `busy`=0, state IDLE. `A` holds its value and `done` is not pulsed.
- `abort` and `start` both high in IDLE: `abort` wins and no sequence starts.
- `MR` during any state: the next edge applies the reset values, including mid-STROBE.
- `start` held high continuously: a new sequence begins on the first IDLE cycle after DONE.
- `count`/`first` changes while busy have no effect.

## Timing
- Edge k samples `start`, giving SETUP after edge k.
- `_E` falls after edge k+1 and rises after edge k+1+`STROBE_CYCLES`.
- Each phase period is `STROBE_CYCLES`+2 cycles.
- `done` is high for the cycle after edge k+(`count`+1)(`STROBE_CYCLES`+2). For `STROBE_CYCLES`=2 and `count`=0, that is edge k+4.
- Minimum `start`-to-`start` repeat is (`count`+1)(`STROBE_CYCLES`+2)+1 cycles.
- `_E` low time per phase is exactly `STROBE_CYCLES` cycles. The guard time (`_E` high with `A` stable) is at least 1 cycle on each side of every address change.

## Structure
- Shared package `phase_seq_pkg`: state enum (IDLE, SETUP, STROBE, HOLD, DONE), 2-bit width constant `ADDR_W`, and the reset constants.
- One natural sub-module, `phase_strobe_timer`: a loadable 4-bit down-counter with load, enable and zero outputs, used for the STROBE dwell.
- The top level contains the FSM, the remaining counter and the address incrementer.
- Benches instantiate `phase_sequencer` driving `hct74139` and check `_Ya` for glitches.

## Test plan
- **Reset:** `MR`=1 for 2 edges → `A`=00, `_E`=1, `busy`=0, `done`=0.
- **Single phase:** `first`=2, `count`=0, `STROBE_CYCLES`=2 → `_Ya`=1011 for exactly 2 cycles, `done` pulse 4 edges after `start`, `_Ya`=1111 elsewhere.
- **Wrap-around:** `first`=3, `count`=3 → `_Ya` strobes 0111, 1110, 1101, 1011 in order. Each strobe is 2 cycles with 2 guard cycles between. `done` comes 16 edges after `start`.
- **Abort mid-STROBE:** `first`=0, `count`=3, `abort` in the 2nd phase's STROBE → `_E`=1 next edge, `busy`=0, no `done`, `A`=01 held.
- **Simultaneous events:** `start`+`abort` in IDLE → stays IDLE. `MR` mid-sequence → reset values next edge. `start` held high → back-to-back sequences separated by one IDLE cycle.
- **Glitch check:** with the hct74139 attached, assert `_Ya` never shows two low bits and never shows a non-target low bit during any address change.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the 74139 phase sequencer.
package phase_seq_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned TMR_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Values every output register returns to on master reset.
  localparam logic [ADDR_W-1:0] RST_A    = '0;
  localparam logic              RST_E_N  = 1'b1;
  localparam logic              RST_BUSY = 1'b0;
  localparam logic              RST_DONE = 1'b0;

endpackage

// File: rtl/phase_strobe_timer.sv
// Loadable down-counter that sets how long the decoder enable stays low.
module phase_strobe_timer
  import phase_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Load has priority; counting stops at zero so the dwell never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Steps a 74139 half-decoder through 1..4 consecutive lines, keeping the
// enable high around every address change so no strobe can glitch.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned LOG           = 0
) (
  input  logic              clk,
  input  logic              MR,
  input  logic              start,
  input  logic [ADDR_W-1:0] first,
  input  logic [1:0]        count,
  input  logic              abort,
  output logic [ADDR_W-1:0] A,
  output logic              _E,
  output logic              busy,
  output logic              done
);

  // Parameter sanity; LOG is kept for interface compatibility and only
  // range-checked, transition tracing lives outside the synthesizable core.
  if ((STROBE_CYCLES < 1) || (STROBE_CYCLES > 15)) begin : g_bad_strobe
    $error("phase_sequencer: STROBE_CYCLES must be 1..15");
  end
  if (LOG > 1) begin : g_bad_log
    $error("phase_sequencer: LOG must be 0 or 1");
  end

  localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(STROBE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              en_n_q, en_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        rem_q, rem_d;
  logic              tmr_load, tmr_en, tmr_zero;

  phase_strobe_timer u_timer (
    .clk        (clk),
    .rst_i      (MR),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (DWELL_LOAD),
    .zero_o     (tmr_zero)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    en_n_d   = 1'b1;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          rem_d   = count;
          a_d     = first;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        busy_d   = 1'b1;
        en_n_d   = 1'b0;
        tmr_load = 1'b1;
        state_d  = STROBE;
      end
      STROBE: begin
        if (tmr_zero) begin
          en_n_d  = 1'b1;
          state_d = HOLD;
        end else begin
          en_n_d  = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      HOLD: begin
        if (rem_q == 2'd0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          a_d     = a_q + ADDR_W'(1);
          rem_d   = rem_q - 2'd1;
          state_d = SETUP;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the active state decided, but leaves A alone.
    if ((state_q != IDLE) && abort) begin
      state_d  = IDLE;
      a_d      = a_q;
      en_n_d   = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      rem_d    = rem_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
    end
  end

  // State and output registers; MR wins over everything else.
  always_ff @(posedge clk) begin
    if (MR) begin
      state_q <= IDLE;
      a_q     <= RST_A;
      en_n_q  <= RST_E_N;
      busy_q  <= RST_BUSY;
      done_q  <= RST_DONE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      en_n_q  <= en_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  assign A    = a_q;
  assign _E   = en_n_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
